// File: rtl/sync_ram_be_dp.sv
// Dual-port synchronous RAM with byte-enabled writes, registered reads and a hardware clear sequencer.
// Define SYNC_RAM_OUTREG_EN to add a second output register stage, which makes the read latency 2.
//   state   | meaning
//   S_CLEAR | zeroing word[r_cnt] each cycle, ports ignored, busy high
//   S_READY | normal read/write service, clr accepted
module sync_ram_be_dp #(
  parameter int DATA  = 16,
  parameter int ADDR  = 5,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR-1:0]   wr_addr,
  input  logic [DATA-1:0]   wr_data,
  input  logic [DATA/8-1:0] wr_be,
  input  logic              rd_en,
  input  logic [ADDR-1:0]   rd_addr,
  output logic [DATA-1:0]   rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);
  localparam int NB = DATA / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR:0]   LIMIT = (ADDR + 1)'(DEPTH);
  localparam logic [IW-1:0]   LAST  = IW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_cnt;
  logic [DATA-1:0] r_mem [DEPTH];
  logic [DATA-1:0] r_rd_data;
  logic            r_rd_valid;
  logic            r_err;

  logic            w_busy, w_accept, w_mem_clr;
  logic            w_wr_in, w_rd_in, w_wr_ok, w_rd_ok, w_err_set;
  logic [IW-1:0]   w_wr_idx, w_rd_idx;
  logic [DATA-1:0] w_rd_word;

  assign w_wr_in  = ({1'b0, wr_addr} < LIMIT);
  assign w_rd_in  = ({1'b0, rd_addr} < LIMIT);
  assign w_wr_idx = wr_addr[IW-1:0];
  assign w_rd_idx = rd_addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == LAST) w_state_nxt = S_READY;
      S_READY: if (clr)           w_state_nxt = S_CLEAR;
    endcase
  end

  // clr and reset both pre-empt any port access in the same cycle
  always_comb begin
    w_busy    = 1'b0;
    w_accept  = 1'b0;
    w_mem_clr = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy    = 1'b1;
        w_mem_clr = !reset;
      end
      S_READY: w_accept = !clr && !reset;
    endcase
  end

  assign w_wr_ok   = w_accept && wr_en && w_wr_in;
  assign w_rd_ok   = w_accept && rd_en;
  assign w_err_set = w_accept && ((wr_en && !w_wr_in) || (rd_en && !w_rd_in));

  always_ff @(posedge clk) begin
    if (reset)                                r_cnt <= '0;
    else if (r_state == S_CLEAR)              r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + IW'(1);
    else if (clr)                             r_cnt <= '0;
  end

  // Write-first, per byte: enabled bytes come from wr_data, the rest from the array
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in) begin
      w_rd_word = r_mem[w_rd_idx];
      if (w_wr_ok && (wr_addr == rd_addr)) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_clr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) r_mem[w_wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_rd_ok) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_rd_word;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                         r_err <= 1'b0;
    else if (r_state == S_READY && clr) r_err <= 1'b0;
    else if (w_err_set)                r_err <= 1'b1;
  end

`ifdef SYNC_RAM_OUTREG_EN
  logic [DATA-1:0] r_rd_data2;
  logic            r_rd_valid2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid2 <= 1'b0;
      r_rd_data2  <= '0;
    end else begin
      r_rd_valid2 <= r_rd_valid;
      r_rd_data2  <= r_rd_data;
    end
  end

  assign rd_data  = r_rd_data2;
  assign rd_valid = r_rd_valid2;
`else
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

  assign busy = w_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_sync_ram_be_dp.sv
// Self-checking bench for sync_ram_be_dp: directed scenarios plus random traffic against a
// word-array reference model that tracks clear time, sticky error and read latency.
module tb_sync_ram_be_dp;
`ifdef SYNC_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, clr, wr_en, rd_en;
  logic [4:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [15:0] rd_data;
  logic        rd_valid, busy, err;

  always #5 clk = ~clk;

  sync_ram_be_dp #(.DATA(16), .ADDR(5), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .err(err)
  );

  typedef struct {
    logic        r, c, we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        re;
    logic [4:0]  ra;
  } op_t;

  // reference model
  logic [15:0] m_mem [16];
  int          m_left;
  logic        m_err;
  logic        s1v, s2v, exp_v, exp_b;
  logic [15:0] s1d, s2d, exp_d;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic op_t mk(logic r, logic c, logic we, logic [4:0] wa, logic [15:0] wd,
                             logic [1:0] be, logic re, logic [4:0] ra);
    op_t o;
    o.r = r; o.c = c; o.we = we; o.wa = wa; o.wd = wd; o.be = be; o.re = re; o.ra = ra;
    return o;
  endfunction

  function automatic op_t idle();                return mk(0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic op_t rd(logic [4:0] a);     return mk(0, 0, 0, 0, 0, 0, 1, a); endfunction
  function automatic op_t wr(logic [4:0] a, logic [15:0] d, logic [1:0] be);
    return mk(0, 0, 1, a, d, be, 0, 0);
  endfunction

  task automatic tick(input op_t o);
    logic [15:0] mask;
    reset = o.r; clr = o.c; wr_en = o.we; wr_addr = o.wa; wr_data = o.wd; wr_be = o.be;
    rd_en = o.re; rd_addr = o.ra;
    if (o.r) begin
      m_left = 16; m_err = 1'b0;
      s1v = 0; s1d = '0; s2v = 0; s2d = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      s2v = s1v; s2d = s1d;
      if (m_left > 0) begin
        m_left--; s1v = 0;
      end else if (o.c) begin
        m_left = 16; m_err = 1'b0; s1v = 0;
        foreach (m_mem[i]) m_mem[i] = '0;
      end else begin
        if (o.we) begin
          mask = {{8{o.be[1]}}, {8{o.be[0]}}};
          if (o.wa < 16) m_mem[o.wa[3:0]] = (m_mem[o.wa[3:0]] & ~mask) | (o.wd & mask);
          else           m_err = 1'b1;
        end
        if (o.re) begin
          s1v = 1;
          if (o.ra < 16) s1d = m_mem[o.ra[3:0]];
          else begin s1d = '0; m_err = 1'b1; end
        end else begin
          s1v = 0;
        end
      end
    end
    exp_v = (LAT == 1) ? s1v : s2v;
    exp_d = (LAT == 1) ? s1d : s2d;
    exp_b = (m_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op_t q[$];
    int  nb;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[k]) begin
      tick(q[k]);
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 k, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end
    nb = 0;
    do begin
      tick(idle());
      nb++;
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL reset_clear[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 nb, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end while (busy && nb < 40);
    n_tests++;
    if (nb !== 16) begin
      n_fail++;
      $display("FAIL reset_busy_len: got %0d cycles, want 16", nb);
    end
    q.delete();
    for (int a = 0; a < 16; a++) q.push_back(rd(5'(a)));
    for (int k = 0; k < LAT; k++) q.push_back(idle());
    foreach (q[k]) begin
      tick(q[k]);
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL reset_read0[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 k, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end
  endtask

  task automatic test_byte_enable();
    op_t         q[$];
    logic [15:0] od [16];
    logic        ov [16];
    q.push_back(wr(3, 16'hABCD, 2'b11));
    q.push_back(wr(3, 16'h1234, 2'b01));
    q.push_back(rd(3));
    for (int k = 0; k < LAT; k++) q.push_back(idle());
    foreach (q[k]) begin
      tick(q[k]);
      od[k] = rd_data; ov[k] = rd_valid;
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL byte_en[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 k, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end
    n_tests++;
    if ({ov[1+LAT], od[1+LAT]} !== {1'b1, 16'hAB34}) begin
      n_fail++;
      $display("FAIL byte_en_merge: got v=%0b d=%h, want v=1 d=ab34", ov[1+LAT], od[1+LAT]);
    end
  endtask

  task automatic test_rdw();
    op_t         q[$];
    logic [15:0] od [16];
    logic        ov [16];
    q.push_back(wr(5, 16'h1122, 2'b11));
    q.push_back(mk(0, 0, 1, 5, 16'h5566, 2'b10, 1, 5));
    for (int k = 0; k < LAT; k++) q.push_back(idle());
    foreach (q[k]) begin
      tick(q[k]);
      od[k] = rd_data; ov[k] = rd_valid;
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL rdw[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 k, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end
    n_tests++;
    if ({ov[LAT], od[LAT]} !== {1'b1, 16'h5522}) begin
      n_fail++;
      $display("FAIL rdw_merge: got v=%0b d=%h, want v=1 d=5522", ov[LAT], od[LAT]);
    end
  endtask

  task automatic test_out_of_range();
    op_t         q[$];
    logic [15:0] od [32];
    logic        ov [32];
    logic        oe [32];
    int          nb;
    q.push_back(wr(20, 16'hFFFF, 2'b11));
    q.push_back(rd(20));
    for (int k = 0; k < LAT; k++) q.push_back(idle());
    for (int a = 0; a < 16; a++) q.push_back(rd(5'(a)));
    for (int k = 0; k < LAT; k++) q.push_back(idle());
    foreach (q[k]) begin
      tick(q[k]);
      od[k] = rd_data; ov[k] = rd_valid; oe[k] = err;
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL oob[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 k, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end
    n_tests++;
    if ({ov[LAT], od[LAT], oe[LAT]} !== {1'b1, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL oob_read: got v=%0b d=%h err=%0b, want v=1 d=0000 err=1", ov[LAT], od[LAT], oe[LAT]);
    end
    tick(mk(0, 1, 0, 0, 0, 0, 0, 0));
    n_tests++;
    if ({busy, err} !== {exp_b, m_err} || {busy, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL oob_clr: got busy=%0b err=%0b, want busy=1 err=0", busy, err);
    end
    nb = 0;
    do begin
      tick(idle());
      nb++;
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL oob_clear[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 nb, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end while (busy && nb < 40);
    n_tests++;
    if (nb !== 16) begin
      n_fail++;
      $display("FAIL oob_busy_len: got %0d cycles, want 16", nb);
    end
  endtask

  task automatic test_clr_priority();
    op_t         q[$];
    logic [15:0] od [32];
    logic        ov [32];
    int          nb;
    int          ridx;
    q.push_back(wr(1, 16'h4444, 2'b11));
    q.push_back(mk(0, 1, 1, 1, 16'h7777, 2'b11, 1, 1));
    for (int k = 0; k < 16; k++) q.push_back(idle());
    ridx = q.size();
    q.push_back(rd(1));
    for (int k = 0; k < LAT; k++) q.push_back(idle());
    foreach (q[k]) begin
      tick(q[k]);
      od[k] = rd_data; ov[k] = rd_valid;
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL clr_prio[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 k, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end
    n_tests++;
    if ({ov[ridx+LAT-1], od[ridx+LAT-1]} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL clr_prio_word1: got v=%0b d=%h, want v=1 d=0000", ov[ridx+LAT-1], od[ridx+LAT-1]);
    end
    // restart clear from count 7
    tick(mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++) tick(idle());
    tick(mk(1, 0, 0, 0, 0, 0, 0, 0));
    nb = 0;
    do begin
      tick(idle());
      nb++;
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL midclr_reset[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 nb, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end while (busy && nb < 40);
    n_tests++;
    if (nb !== 16) begin
      n_fail++;
      $display("FAIL midclr_busy_len: got %0d cycles, want 16", nb);
    end
  endtask

  task automatic test_back_to_back();
    op_t         q[$];
    logic [15:0] od [16];
    logic        ov [16];
    logic [15:0] dv [3];
    for (int k = 0; k < 3; k++) begin
      dv[k] = 16'($urandom);
      q.push_back(wr(5'(2 + k), dv[k], 2'b11));
    end
    for (int k = 0; k < 3; k++) q.push_back(rd(5'(2 + k)));
    for (int k = 0; k < LAT; k++) q.push_back(idle());
    foreach (q[k]) begin
      tick(q[k]);
      od[k] = rd_data; ov[k] = rd_valid;
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 k, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end
    n_tests++;
    if (ov[1+LAT] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_early_valid: got v=%0b, want v=0", ov[1+LAT]);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({ov[2+LAT+k], od[2+LAT+k]} !== {1'b1, dv[k]}) begin
        n_fail++;
        $display("FAIL b2b_read%0d: got v=%0b d=%h, want v=1 d=%h", k, ov[2+LAT+k], od[2+LAT+k], dv[k]);
      end
    end
  endtask

  task automatic test_random();
    op_t o;
    for (int k = 0; k < 600; k++) begin
      o.r  = ($urandom_range(0, 249) == 0);
      o.c  = ($urandom_range(0, 79) == 0);
      o.we = $urandom_range(0, 1);
      o.wa = 5'($urandom_range(0, 17));
      o.wd = 16'($urandom);
      o.be = 2'($urandom);
      o.re = $urandom_range(0, 1);
      o.ra = ($urandom_range(0, 2) == 0) ? o.wa : 5'($urandom_range(0, 17));
      tick(o);
      n_tests++;
      if ({rd_valid, rd_data, busy, err} !== {exp_v, exp_d, exp_b, m_err}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b d=%h busy=%0b err=%0b, want v=%0b d=%h busy=%0b err=%0b",
                 k, rd_valid, rd_data, busy, err, exp_v, exp_d, exp_b, m_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    m_left = 16; m_err = 1'b0;
    s1v = 0; s2v = 0; s1d = '0; s2d = '0;
    exp_v = 0; exp_d = '0; exp_b = 1;
    foreach (m_mem[i]) m_mem[i] = '0;
    test_reset();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_clr_priority();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
